// File: rtl/seq_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_scan_ctrl_pkg
// Purpose  : Shared encodings and helpers for the seq_scan_ctrl block:
//            controller state encoding, default 1010 pattern and the width
//            function used for the per-word hit counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [3:0] PAT_1010 = 4'b1010;

    // Bits needed to hold a hit count in the range 0..data_w.
    function automatic int count_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage : seq_scan_ctrl_pkg
`default_nettype wire

// File: rtl/seq_scan_ctrl_pattern_window.sv
`default_nettype none
// ============================================================================
// Module   : seq_scan_ctrl_pattern_window
// Purpose  : Bit-serial pattern window. Holds the last PAT_W consumed bits and
//            a saturating fill count, and flags a hit when the window (after
//            taking the current bit) is full and equals PAT.
// Ports    : clk, rst (async, active-low)
//            shift_en - consume cur this cycle
//            cur      - bit being consumed
//            clear    - empty the window (new unchained word)
//            overlap  - 1: matched bits may be reused, 0: restart after hit
//            hit      - combinational: this cycle's consume completes a match
// Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl_pattern_window
    import seq_scan_ctrl_pkg::*;
#(
    parameter int               PAT_W = 4,
    parameter logic [PAT_W-1:0] PAT   = PAT_1010
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic cur,
    input  logic clear,
    input  logic overlap,
    output logic hit
);

    localparam int              FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_q;
    logic [PAT_W-1:0]  window_d;
    logic [PAT_W-1:0]  window_n;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_n;

    always_comb begin
        window_n = {window_q[PAT_W-2:0], cur};
        fill_n   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        hit      = shift_en && (fill_n == FILL_FULL) && (window_n == PAT);

        window_d = window_q;
        fill_d   = fill_q;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_en) begin
            window_d = window_n;
            // Non-overlap: emptying the fill count guarantees the next hit
            // needs PAT_W fresh bits; the window contents no longer matter.
            fill_d   = (hit && !overlap) ? '0 : fill_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule : seq_scan_ctrl_pattern_window
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_scan_ctrl
// Purpose  : Accepts a DATA_W-bit word on a start/ready handshake and shifts
//            it MSB-first, one bit per clock, through a pattern window,
//            reporting per-bit hit strobes and a per-word hit count.
// Ports    : clk, rst (async, active-low)
//            start, data_i, overlap_i, chain_i - request and word options,
//                                                sampled on the accept edge
//            ready_o - idle, busy_o - shifting, bit_o - bit being consumed
//            hit_o   - one cycle per completed match
//            done_o  - one-cycle pulse after the last bit
//            count_o - hits in the current/last word
// Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               PAT_W  = 4,
    parameter logic [PAT_W-1:0] PAT    = PAT_1010
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             overlap_i,
    input  logic                             chain_i,
    output logic                             ready_o,
    output logic                             busy_o,
    output logic                             bit_o,
    output logic                             hit_o,
    output logic                             done_o,
    output logic [count_width(DATA_W)-1:0]   count_o
);

    localparam int                CNT_W    = count_width(DATA_W);
    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    state_e             state_q;
    logic [DATA_W-1:0]  sreg_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   count_q;
    logic               overlap_q;
    logic               ready_q;
    logic               busy_q;
    logic               hit_q;
    logic               done_q;

    logic               accept;
    logic               shift_en;
    logic               win_clear;
    logic               win_hit;

    assign accept    = (state_q == ST_IDLE) && start;
    assign shift_en  = (state_q == ST_SHIFT);
    // chain_i only matters at the accept edge, so it is used directly
    // there rather than latched.
    assign win_clear = accept && !chain_i;

    seq_scan_ctrl_pattern_window #(
        .PAT_W (PAT_W),
        .PAT   (PAT)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .cur      (sreg_q[DATA_W-1]),
        .clear    (win_clear),
        .overlap  (overlap_q),
        .hit      (win_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            overlap_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_SHIFT;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        sreg_q    <= data_i;
                        idx_q     <= '0;
                        count_q   <= '0;
                        overlap_q <= overlap_i;
                    end
                end
                ST_SHIFT: begin
                    sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
                    idx_q  <= idx_q + 1'b1;
                    // At most one hit per consumed bit, so count_q cannot
                    // pass DATA_W and needs no saturation.
                    if (win_hit) begin
                        hit_q   <= 1'b1;
                        count_q <= count_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign bit_o   = sreg_q[DATA_W-1];
    assign hit_o   = hit_q;
    assign done_o  = done_q;
    assign count_o = count_q;

endmodule : seq_scan_ctrl
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_scan_ctrl
// Purpose  : Directed scoreboard bench for seq_scan_ctrl (DATA_W=8, 1010).
//            The driver pushes the expected bit sequence, hit positions and
//            count for every word; an independent monitor rebuilds them from
//            the DUT outputs and compares when done_o is seen.
//            Hit masks use bit k = hit after word bit k (k=0 is the MSB).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic             overlap_i = 1'b0;
    logic             chain_i = 1'b0;
    logic             ready_o;
    logic             busy_o;
    logic             bit_o;
    logic             hit_o;
    logic             done_o;
    logic [CNT_W-1:0] count_o;

    seq_scan_ctrl #(
        .DATA_W (DATA_W),
        .PAT_W  (4),
        .PAT    (4'b1010)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_i    (data_i),
        .overlap_i (overlap_i),
        .chain_i   (chain_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .bit_o     (bit_o),
        .hit_o     (hit_o),
        .done_o    (done_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [7:0] mask;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference for unchained words: slide over the word MSB-first; in
    // non-overlap mode a candidate must start after the previous match end.
    function automatic logic [7:0] ref_mask(input logic [7:0] w, input bit ov);
        logic [7:0] m;
        int         last_end;
        m        = '0;
        last_end = -1;
        for (int k = 3; k < 8; k++) begin
            logic [3:0] seg;
            for (int j = 0; j < 4; j++) seg[3-j] = w[7-(k-3+j)];
            if (seg == 4'b1010 && (ov || (k - 3 > last_end))) begin
                m[k]     = 1'b1;
                last_end = k;
            end
        end
        return m;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (ready_o !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", {31'b0, ready_o}, 32'd1);
    endtask

    task automatic accept_word(input logic [7:0] w, input bit ov, input bit ch);
        @(negedge clk);
        wait_ready();
        start     = 1'b1;
        data_i    = w;
        overlap_i = ov;
        chain_i   = ch;
        @(posedge clk);
        #1;
        // Scramble the request inputs: they must not affect the running word.
        start     = 1'b0;
        data_i    = 8'($urandom);
        overlap_i = ~ov;
        chain_i   = ~ch;
    endtask

    task automatic scan(input logic [7:0] w, input bit ov, input bit ch, input logic [7:0] m);
        exp_q.push_back('{w, m, $countones(m)});
        n_vec++;
        accept_word(w, ov, ch);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        int         idx;
        bit         in_word;
        bit         prev_done;
        logic [7:0] bits;
        logic [7:0] hits;
        exp_t       e;
        idx = 0; in_word = 0; prev_done = 0; bits = '0; hits = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_word   = 0;
                idx       = 0;
                prev_done = 0;
                continue;
            end
            if (prev_done) begin
                chk("done_width", {31'b0, done_o}, 32'd0);
                prev_done = 0;
            end
            if (busy_o) begin
                if (!in_word) begin
                    in_word = 1; idx = 0; bits = '0; hits = '0;
                end
                chk("ready_in_shift", {31'b0, ready_o}, 32'd0);
                if (idx < 8) bits[7-idx] = bit_o;
                if (idx >= 1 && idx <= 8 && hit_o) hits[idx-1] = 1'b1;
                idx++;
            end else if (done_o) begin
                if (hit_o) hits[7] = 1'b1;
                chk("ready_in_done", {31'b0, ready_o}, 32'd0);
                chk("busy_len", idx, 32'd8);
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done_o with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit_seq", bits, e.word);
                    chk("hit_pos", hits, e.mask);
                    chk("count", count_o, e.cnt);
                end
                in_word   = 0;
                prev_done = 1;
            end else begin
                chk("idle_hit", {31'b0, hit_o}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin : driver
        int cyc;
        int last;
        int accepts;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_busy",  {31'b0, busy_o},  32'd0);
        chk("rst_done",  {31'b0, done_o},  32'd0);
        chk("rst_hit",   {31'b0, hit_o},   32'd0);
        chk("rst_bit",   {31'b0, bit_o},   32'd0);
        chk("rst_count", count_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1010 over 0xAA / 0x55, both modes
        scan(8'hAA, 1'b1, 1'b0, 8'hA8);
        scan(8'hAA, 1'b0, 1'b0, 8'h88);
        scan(8'h55, 1'b1, 1'b0, 8'h50);
        scan(8'h55, 1'b0, 1'b0, 8'h10);
        drain();

        // Chaining: 0x05 leaves 0101 in the window; 0x00 completes 1010 at bit 0
        scan(8'h05, 1'b1, 1'b0, 8'h00);
        scan(8'h00, 1'b1, 1'b1, 8'h01);
        scan(8'h05, 1'b1, 1'b0, 8'h00);
        scan(8'h00, 1'b1, 1'b0, 8'h00);
        drain();

        // Reset during bit 4 of a word (one hit already counted)
        accept_word(8'hAA, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, ready_o}, 32'd1);
        chk("mid_rst_busy",  {31'b0, busy_o},  32'd0);
        chk("mid_rst_count", count_o, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_done", {31'b0, done_o}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_done",  {31'b0, done_o},  32'd0);
            chk("post_rst_ready", {31'b0, ready_o}, 32'd1);
        end
        scan(8'hAA, 1'b1, 1'b1, 8'hA8);
        drain();

        // start held high, data changing every cycle. Accept edges are
        // DATA_W SHIFT cycles + one DONE + one IDLE apart.
        cyc = 0; last = -1; accepts = 0;
        while (accepts < 3 && cyc < 200) begin
            @(negedge clk);
            start     = 1'b1;
            data_i    = 8'($urandom);
            overlap_i = 1'b1;
            chain_i   = 1'b0;
            if (ready_o === 1'b1) begin
                exp_q.push_back('{data_i, ref_mask(data_i, 1'b1), $countones(ref_mask(data_i, 1'b1))});
                n_vec++;
                if (last >= 0) chk("accept_gap", cyc - last, DATA_W + 2);
                last = cyc;
                accepts++;
            end
            cyc++;
        end
        chk("accept_timeout", accepts, 32'd3);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back words
        scan(8'hFF, 1'b1, 1'b0, 8'h00);
        scan(8'h00, 1'b1, 1'b0, 8'h00);
        scan(8'hA5, 1'b1, 1'b0, 8'h08);
        drain();

        // count_o holds its value in IDLE
        repeat (3) @(negedge clk);
        chk("count_hold", count_o, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_scan_ctrl
`default_nettype wire
